mem_arbiter: RTL and testbench

- Shares one single-port synchronous BRAM (1-cycle read latency) between the instruction-fetch port (I) and the load/store port (D).
- Arbitrates each cycle: D has priority, with a starvation guard for I.
- Generates byte-lane write masks and lane-aligned write data from access size and the low address bits.
- Returns read data to whichever port issued the read. Sits between the core pipeline and the unified memory.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_align.sv | 37 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter and its store lane aligner.
package mem_arbiter_pkg;

    // Access size as presented on d_size; 11 behaves as a word access.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    // Which port the read in flight belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

    // Byte-lane masks before shifting into position.
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter_align.sv
// Store lane aligner: turns size + low address bits + LSB-justified data into
// byte enables, lane-replicated data and a misalignment flag.
module store_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] lane_data,
    output logic        misalign
);

    // Decode the access size into lane mask, replicated data and alignment.
    always_comb begin
        mask      = MASK_NONE;
        lane_data = wdata;
        misalign  = 1'b0;
        case (size_t'(size))
            SZ_BYTE: begin
                mask      = MASK_BYTE << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask      = MASK_HALF << {addr_lo[1], 1'b0};
                lane_data = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            default: begin
                mask      = MASK_WORD;
                lane_data = wdata;
                misalign  = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port 1-cycle-latency BRAM between the fetch port
// (I) and the load/store port (D). D has priority; a starve counter lets I
// win once after STARVE_LIMIT consecutive denials.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]  starve;
    owner_t      owner;
    logic        mis_load;
    logic        sel_i;
    logic        sel_d;
    logic        d_mis;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic [31:0] i_hold;
    logic [31:0] d_hold;
    logic        unused_addr_bits;

    // Word addressing drops the byte offset and anything above the memory depth.
    assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

    store_lane_align u_align (
        .size      (d_size),
        .addr_lo   (d_addr[1:0]),
        .wdata     (d_wdata),
        .mask      (lane_mask),
        .lane_data (lane_data),
        .misalign  (d_mis)
    );

    // Pick the winner this cycle; nothing is granted while reset is held.
    always_comb begin
        sel_i = !rst && i_req && (!d_req || (starve == STARVE_MAX));
        sel_d = !rst && d_req && !sel_i;
    end

    assign i_gnt = sel_i;
    assign d_gnt = sel_d;

    // Drive the memory port from the winner; misaligned D accesses touch nothing.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = MASK_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sel_i) begin
            mem_en   = 1'b1;
            mem_addr = i_addr[ADDR_W+1:2];
        end else if (sel_d) begin
            mem_addr = d_addr[ADDR_W+1:2];
            if (!d_mis) begin
                mem_en = 1'b1;
                if (d_we) begin
                    mem_we    = lane_mask;
                    mem_wdata = lane_data;
                end
            end
        end
    end

    // Count consecutive cycles I waits, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (!i_req || sel_i) begin
            starve <= '0;
        end else if (starve != STARVE_MAX) begin
            starve <= starve + 4'd1;
        end
    end

    // Track which port owns the returning read and raise the response strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_NONE;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            d_misalign <= 1'b0;
            mis_load   <= 1'b0;
        end else begin
            if (sel_i) begin
                owner <= OWN_I;
            end else if (sel_d && !d_we && !d_mis) begin
                owner <= OWN_D;
            end else begin
                owner <= OWN_NONE;
            end
            i_rvalid   <= sel_i;
            d_rvalid   <= sel_d && !d_we;
            d_misalign <= sel_d && d_mis;
            mis_load   <= sel_d && !d_we && d_mis;
        end
    end

    // Remember the last delivered word so rdata holds while rvalid is low.
    always_ff @(posedge clk) begin
        if (owner == OWN_I) begin
            i_hold <= mem_rdata;
        end
        if (d_rvalid) begin
            d_hold <= d_rdata;
        end
    end

    assign i_rdata = (owner == OWN_I) ? mem_rdata : i_hold;
    assign d_rdata = (owner == OWN_D) ? mem_rdata : (mis_load ? 32'h0 : d_hold);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle BRAM.
module tb_mem_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_misalign;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_misalign(d_misalign),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // BRAM model: word k preloads to 0xA500_0000 + k while reset is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < (1<<ADDR_W); k++) mem[k] <= 32'hA500_0000 + k;
        end else if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_size = 2'b10; d_addr = 0; d_wdata = 0;
    endtask

    task automatic dop(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        // Reset: registered outputs low, requests ignored.
        i_req = 1; d_req = 1; #1;
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_d_misalign", d_misalign, 0);
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        idle();
        rst = 0;
        tick();

        // I-only stream of four fetches.
        for (int k = 0; k < 4; k++) begin
            i_req = 1; i_addr = 32'(4*k); #1;
            chk("istr_gnt", i_gnt, 1);
            chk("istr_dgnt", d_gnt, 0);
            chk("istr_addr", 32'(mem_addr), 32'(k));
            tick();
            chk("istr_rvalid", i_rvalid, 1);
            chk("istr_rdata", i_rdata, 32'hA500_0000 + 32'(k));
            chk("istr_d_rvalid", d_rvalid, 0);
        end
        idle(); tick();
        chk("istr_rvalid_end", i_rvalid, 0);
        chk("istr_hold", i_rdata, 32'hA500_0003);

        // Store lanes.
        dop(1, 2'b10, 32'h100, 32'hDEADBEEF); #1;
        chk("sw_gnt", d_gnt, 1);
        chk("sw_we", 32'(mem_we), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_addr", 32'(mem_addr), 32'h40);
        tick();
        dop(1, 2'b01, 32'h102, 32'h0000_1234); #1;
        chk("sh_we", 32'(mem_we), 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("st_no_rvalid", d_rvalid, 0);
        tick();
        dop(1, 2'b00, 32'h100, 32'hFFFF_FFAB); #1;
        chk("sb0_we", 32'(mem_we), 32'h1);
        chk("sb0_wdata", mem_wdata, 32'hABAB_ABAB);
        tick();
        dop(1, 2'b00, 32'h107, 32'h0000_00AB); #1;
        chk("sb3_we", 32'(mem_we), 32'h8);
        chk("sb3_wdata", mem_wdata, 32'hABAB_ABAB);
        tick();
        dop(1, 2'b11, 32'h10C, 32'h1122_3344); #1;
        chk("s11_we", 32'(mem_we), 32'hF);
        tick();
        dop(0, 2'b10, 32'h100, 32'h0); #1;
        chk("lw_en", mem_en, 1);
        chk("lw_we", 32'(mem_we), 32'h0);
        tick();
        chk("lw_rvalid", d_rvalid, 1);
        chk("lw_rdata", d_rdata, 32'h1234_BEAB);
        chk("lw_no_i", i_rvalid, 0);
        dop(0, 2'b10, 32'h104, 32'h0);
        tick();
        chk("lw104_rdata", d_rdata, 32'hAB00_0041);

        // Store right after a load of the same word.
        dop(0, 2'b10, 32'h108, 32'h0);
        tick();
        dop(1, 2'b10, 32'h108, 32'h5566_7788); #1;
        chk("raw_we", 32'(mem_we), 32'hF);
        chk("raw_rvalid", d_rvalid, 1);
        chk("raw_rdata", d_rdata, 32'hA500_0042);
        tick();
        idle();
        chk("raw_rvalid_end", d_rvalid, 0);
        chk("raw_hold", d_rdata, 32'hA500_0042);
        dop(0, 2'b10, 32'h108, 32'h0);
        tick();
        chk("raw_readback", d_rdata, 32'h5566_7788);
        idle(); tick();

        // Contention: D wins four times, then I once, then D again.
        i_req = 1; i_addr = 32'h10;
        dop(0, 2'b10, 32'h20, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("cont_i_gnt%0d", c), i_gnt, (c == 4));
            chk($sformatf("cont_d_gnt%0d", c), d_gnt, (c != 4));
            tick();
        end
        idle(); tick(); tick();

        // Misaligned store: granted but no memory effect.
        dop(1, 2'b10, 32'h102, 32'hFFFF_FFFF); #1;
        chk("mis_sw_gnt", d_gnt, 1);
        chk("mis_sw_en", mem_en, 0);
        chk("mis_sw_we", 32'(mem_we), 32'h0);
        tick();
        idle();
        chk("mis_sw_pulse", d_misalign, 1);
        chk("mis_sw_no_rv", d_rvalid, 0);
        tick();
        chk("mis_sw_pulse_end", d_misalign, 0);
        dop(0, 2'b10, 32'h100, 32'h0);
        tick();
        chk("mis_sw_unchanged", d_rdata, 32'h1234_BEAB);
        // Misaligned half load returns zero.
        dop(0, 2'b01, 32'h101, 32'h0); #1;
        chk("mis_lh_gnt", d_gnt, 1);
        chk("mis_lh_en", mem_en, 0);
        tick();
        idle();
        chk("mis_lh_rvalid", d_rvalid, 1);
        chk("mis_lh_rdata", d_rdata, 32'h0);
        chk("mis_lh_pulse", d_misalign, 1);
        tick();

        // Interleave: I read then D load, no cross-delivery.
        i_req = 1; i_addr = 32'h10; #1;
        chk("il_i_gnt", i_gnt, 1);
        tick();
        i_req = 0;
        dop(0, 2'b10, 32'h20, 32'h0); #1;
        chk("il_d_gnt", d_gnt, 1);
        chk("il_i_rvalid", i_rvalid, 1);
        chk("il_i_rdata", i_rdata, 32'hA500_0004);
        chk("il_d_rvalid0", d_rvalid, 0);
        tick();
        idle();
        chk("il_d_rvalid", d_rvalid, 1);
        chk("il_d_rdata", d_rdata, 32'hA500_0008);
        chk("il_i_rvalid0", i_rvalid, 0);
        chk("il_i_hold", i_rdata, 32'hA500_0004);
        tick();

        // Reset in the cycle after a load grant drops the return.
        dop(0, 2'b10, 32'h0, 32'h0); #1;
        chk("rmid_gnt", d_gnt, 1);
        tick();
        rst = 1; #1;
        chk("rmid_d_rvalid", d_rvalid, 0);
        chk("rmid_i_rvalid", i_rvalid, 0);
        chk("rmid_misalign", d_misalign, 0);
        chk("rmid_d_gnt", d_gnt, 0);
        chk("rmid_mem_en", mem_en, 0);
        tick();
        idle();
        rst = 0;
        tick();
        chk("rmid_after1", d_rvalid, 0);
        tick();
        chk("rmid_after2", d_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
